// File: rtl/lcd_serial_receiver.sv
// Receive side of the 4-wire serial LCD link: deserialises bytes, decodes panel
// commands and emits frame-buffer writes laid out as page*128+col.
module lcd_serial_receiver #(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] lcd,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic [2:0] cur_page,
    output logic [7:0] cur_col,
    output logic       display_on,
    output logic       frame_done,
    output logic       err_short
);

    // Line order in lcd: [0]=CS, [1]=SCL, [2]=A0, [3]=SI. CS and SCL idle high.
    localparam logic [3:0] SYNC_INIT = 4'b0011;
    localparam logic [7:0] COL_LIMIT = 8'(COLS);
    localparam logic [7:0] LAST_COL  = 8'(COLS - 1);
    localparam logic [2:0] LAST_PAGE = 3'(PAGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg[gi] <= SYNC_INIT[gi];
                    sync_reg[gi] <= SYNC_INIT[gi];
                end else begin
                    meta_reg[gi] <= lcd[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    // Edge detection stage: the rise strobe is registered together with the
    // SI/A0/CS values seen in the same cycle so the FSM sees them aligned.
    logic scl_prev_reg;
    logic rise_reg;
    logic si_reg;
    logic a0_reg;
    logic cs_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev_reg <= 1'b1;
            rise_reg     <= 1'b0;
            si_reg       <= 1'b0;
            a0_reg       <= 1'b0;
            cs_reg       <= 1'b1;
        end else begin
            scl_prev_reg <= sync_reg[1];
            rise_reg     <= sync_reg[1] & ~scl_prev_reg;
            si_reg       <= sync_reg[3];
            a0_reg       <= sync_reg[2];
            cs_reg       <= sync_reg[0];
        end
    end

    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [6:0] shift_reg;
    logic [7:0] byte_reg;
    logic       byte_a0_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 7'd0;
            byte_reg    <= 8'd0;
            byte_a0_reg <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= 10'd0;
            fb_wdata    <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'd0;
            cur_page    <= 3'd0;
            cur_col     <= 8'd0;
            display_on  <= 1'b0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            fb_we      <= 1'b0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= 3'd0;
                    if (!cs_reg) begin
                        state_reg <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (rise_reg) begin
                        shift_reg <= {shift_reg[5:0], si_reg};
                        if (bit_cnt_reg == 3'd7) begin
                            byte_reg    <= {shift_reg, si_reg};
                            byte_a0_reg <= a0_reg;
                            bit_cnt_reg <= 3'd0;
                            state_reg   <= COMMIT;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end else if (cs_reg) begin
                        // CS released mid-byte: the partial byte is dropped.
                        if (bit_cnt_reg != 3'd0) begin
                            err_short <= 1'b1;
                        end
                        bit_cnt_reg <= 3'd0;
                        state_reg   <= IDLE;
                    end
                end

                COMMIT: begin
                    state_reg <= cs_reg ? IDLE : SHIFT;
                    if (byte_a0_reg) begin
                        if (cur_col < COL_LIMIT) begin
                            fb_we    <= 1'b1;
                            fb_addr  <= {cur_page, cur_col[6:0]};
                            fb_wdata <= byte_reg;
                            if (cur_page == LAST_PAGE && cur_col == LAST_COL) begin
                                frame_done <= 1'b1;
                            end
                        end
                        // Column keeps advancing past the visible area, wrapping at 255.
                        cur_col <= cur_col + 8'd1;
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd_byte  <= byte_reg;
                        if (byte_reg[7:3] == 5'b10110) begin
                            cur_page <= byte_reg[2:0];
                        end else if (byte_reg[7:4] == 4'h1) begin
                            cur_col[7:4] <= byte_reg[3:0];
                        end else if (byte_reg[7:4] == 4'h0) begin
                            cur_col[3:0] <= byte_reg[3:0];
                        end else if (byte_reg == 8'hAF) begin
                            display_on <= 1'b1;
                        end else if (byte_reg == 8'hAE) begin
                            display_on <= 1'b0;
                        end else if (byte_reg == 8'hE2) begin
                            cur_page   <= 3'd0;
                            cur_col    <= 8'd0;
                            display_on <= 1'b0;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_serial_receiver.sv
// Directed bench for lcd_serial_receiver: drives the serial link and checks
// decoded state and strobe counts against hand-computed values.
module tb_lcd_serial_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs  = 1'b1;
    logic       scl = 1'b1;
    logic       a0  = 1'b0;
    logic       si  = 1'b0;
    logic [3:0] lcd;

    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic [2:0] cur_page;
    logic [7:0] cur_col;
    logic       display_on;
    logic       frame_done;
    logic       err_short;

    assign lcd = {si, a0, scl, cs};

    always #5 clk = ~clk;

    lcd_serial_receiver #(.COLS(128), .PAGES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd        (lcd),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .cur_page   (cur_page),
        .cur_col    (cur_col),
        .display_on (display_on),
        .frame_done (frame_done),
        .err_short  (err_short)
    );

    int errors = 0;
    int checks = 0;

    // Strobe monitor, sampled on the falling edge away from DUT updates.
    int         we_cnt   = 0;
    int         cmd_cnt  = 0;
    int         fd_cnt   = 0;
    int         err_cnt  = 0;
    int         bad_data = 0;
    logic [9:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [9:0] fd_addr   = '0;
    logic       rec = 1'b0;
    int         hits [1024];

    always @(negedge clk) begin
        if (fb_we) begin
            we_cnt++;
            last_addr = fb_addr;
            last_data = fb_wdata;
            if (rec) begin
                hits[fb_addr]++;
                if (fb_wdata != fb_addr[7:0]) bad_data++;
            end
        end
        if (cmd_valid) cmd_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_addr = fb_addr;
        end
        if (err_short) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic a, input logic b);
        scl = 1'b0;
        a0  = a;
        si  = b;
        clk_n(2);
        scl = 1'b1;
        clk_n(2);
    endtask

    task automatic send_byte(input logic a, input logic [7:0] b);
        if (cs) begin
            cs = 1'b0;
            clk_n(3);
        end
        for (int i = 7; i >= 0; i--) put_bit(a, b[i]);
    endtask

    task automatic end_cs();
        clk_n(6);
        cs = 1'b1;
        clk_n(6);
    endtask

    int base_we, base_cmd, base_fd, base_err, nbad;

    initial begin
        clk_n(5);
        check_eq("reset fb_we", fb_we, 0);
        check_eq("reset cmd_valid", cmd_valid, 0);
        check_eq("reset cur_page", cur_page, 0);
        check_eq("reset cur_col", cur_col, 0);
        check_eq("reset display_on", display_on, 0);
        check_eq("reset frame_done", frame_done, 0);
        check_eq("reset err_short", err_short, 0);
        rst = 1'b0;
        clk_n(4);

        // 1: command sequence back to back under one CS
        base_cmd = cmd_cnt; base_we = we_cnt;
        send_byte(1'b0, 8'hE2);
        send_byte(1'b0, 8'hAF);
        send_byte(1'b0, 8'hB3);
        send_byte(1'b0, 8'h10);
        send_byte(1'b0, 8'h05);
        end_cs();
        check_eq("t1 cmd pulses", cmd_cnt - base_cmd, 5);
        check_eq("t1 display_on", display_on, 1);
        check_eq("t1 cur_page", cur_page, 3);
        check_eq("t1 cur_col", cur_col, 5);
        check_eq("t1 cmd_byte", cmd_byte, 8'h05);
        check_eq("t1 no writes", we_cnt - base_we, 0);

        // 2: single data byte at page 3 col 5
        base_we = we_cnt;
        send_byte(1'b1, 8'hA5);
        end_cs();
        check_eq("t2 writes", we_cnt - base_we, 1);
        check_eq("t2 fb_addr", last_addr, 389);
        check_eq("t2 fb_wdata", last_data, 8'hA5);
        check_eq("t2 cur_col", cur_col, 6);

        // 3: last visible column then one past it
        send_byte(1'b0, 8'hB0);
        send_byte(1'b0, 8'h17);
        send_byte(1'b0, 8'h0F);
        end_cs();
        check_eq("t3 col set", cur_col, 127);
        base_we = we_cnt; base_fd = fd_cnt;
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        end_cs();
        check_eq("t3 writes", we_cnt - base_we, 1);
        check_eq("t3 fb_addr", last_addr, 127);
        check_eq("t3 fb_wdata", last_data, 8'h11);
        check_eq("t3 cur_col", cur_col, 129);
        check_eq("t3 no frame_done", fd_cnt - base_fd, 0);

        // 4: full frame, data byte = low 8 bits of its address
        base_we = we_cnt; base_fd = fd_cnt; base_err = err_cnt;
        rec = 1'b1;
        for (int p = 0; p < 8; p++) begin
            send_byte(1'b0, 8'hB0 + 8'(p));
            send_byte(1'b0, 8'h10);
            send_byte(1'b0, 8'h00);
            for (int c = 0; c < 128; c++) send_byte(1'b1, 8'(p * 128 + c));
        end
        end_cs();
        rec = 1'b0;
        nbad = 0;
        for (int i = 0; i < 1024; i++) if (hits[i] != 1) nbad++;
        check_eq("t4 writes", we_cnt - base_we, 1024);
        check_eq("t4 addr not hit once", nbad, 0);
        check_eq("t4 bad data", bad_data, 0);
        check_eq("t4 frame_done", fd_cnt - base_fd, 1);
        check_eq("t4 frame_done addr", fd_addr, 1023);
        check_eq("t4 cur_page", cur_page, 7);
        check_eq("t4 cur_col", cur_col, 128);
        check_eq("t4 no err_short", err_cnt - base_err, 0);

        // 5: short transfer of 5 bits
        base_we = we_cnt; base_cmd = cmd_cnt; base_err = err_cnt;
        cs = 1'b0;
        clk_n(3);
        for (int i = 0; i < 5; i++) put_bit(1'b1, 1'b1);
        end_cs();
        check_eq("t5 err_short", err_cnt - base_err, 1);
        check_eq("t5 no writes", we_cnt - base_we, 0);
        check_eq("t5 no cmds", cmd_cnt - base_cmd, 0);
        send_byte(1'b0, 8'hB5);
        end_cs();
        check_eq("t5 recovery page", cur_page, 5);
        check_eq("t5 recovery cmd_byte", cmd_byte, 8'hB5);
        check_eq("t5 recovery cmd count", cmd_cnt - base_cmd, 1);

        // 6: reset in the middle of a data byte
        cs = 1'b0;
        clk_n(3);
        for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b1);
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0;
        check_eq("t6 rst cur_page", cur_page, 0);
        check_eq("t6 rst cur_col", cur_col, 0);
        check_eq("t6 rst display_on", display_on, 0);
        check_eq("t6 rst cmd_byte", cmd_byte, 0);
        base_we = we_cnt; base_cmd = cmd_cnt; base_err = err_cnt;
        end_cs();
        send_byte(1'b0, 8'hAF);
        end_cs();
        check_eq("t6 display_on", display_on, 1);
        check_eq("t6 cmd count", cmd_cnt - base_cmd, 1);
        check_eq("t6 no stray writes", we_cnt - base_we, 0);
        check_eq("t6 no err_short", err_cnt - base_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
